// File: rtl/imem_loader.sv
// Purpose: 256x16 instruction memory, filled by a byte-serial framed load that holds the CPU until it finishes.
// Latency: i_datain is combinational from i_addr; a word is written on the edge that accepts its low byte.
// Backpressure: rx_ready is high only while a load is active and load_en is high; bytes are taken on rx_valid & rx_ready.
module imem_loader #(
  parameter logic [7:0] BASE_ADDR = 8'h00
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        load_en,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  input  logic [7:0]  i_addr,
  output logic [15:0] i_datain,
  output logic        cpu_hold,
  output logic        cpu_start,
  output logic        load_done,
  output logic        load_err,
  output logic [8:0]  word_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_HI,
    S_LO,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_t;

  state_t      state_q, state_d;
  logic        load_en_q, load_en_d;
  logic [7:0]  ptr_q, ptr_d;
  logic [7:0]  acc_q, acc_d;
  logic [7:0]  hi_q, hi_d;
  logic [8:0]  len_q, len_d;
  logic [8:0]  wc_q, wc_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        start_q, start_d;

  logic        active;
  logic        accept;
  logic        rise;
  logic        mem_we;
  logic [7:0]  mem_waddr;
  logic [15:0] mem_wdata;

  // Storage is deliberately left out of reset so a reset never wipes a loaded program.
  logic [15:0] mem [0:255];

  // Loading phases are the only ones that own the CPU and the byte port.
  always_comb begin
    active   = (state_q == S_LEN) || (state_q == S_HI) ||
               (state_q == S_LO)  || (state_q == S_CSUM);
    cpu_hold = active;
    // Gating by load_en keeps a byte from being swallowed in the abort cycle.
    rx_ready = active & load_en;
    accept   = rx_valid & rx_ready;
    rise     = load_en & ~load_en_q;
  end

  // Next-state, frame parsing and memory write strobe.
  always_comb begin
    state_d   = state_q;
    load_en_d = load_en;
    ptr_d     = ptr_q;
    acc_d     = acc_q;
    hi_d      = hi_q;
    len_d     = len_q;
    wc_d      = wc_q;
    done_d    = done_q;
    err_d     = err_q;
    start_d   = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = ptr_q;
    mem_wdata = {hi_q, rx_data};

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (rise) begin
          // Entering LEN starts a fresh frame: status and counters are cleared here.
          state_d = S_LEN;
          done_d  = 1'b0;
          err_d   = 1'b0;
          wc_d    = 9'd0;
          acc_d   = 8'd0;
          ptr_d   = BASE_ADDR;
        end
      end
      S_LEN, S_HI, S_LO, S_CSUM: begin
        if (!load_en) begin
          // Abort: partial words and word_count are kept as a record of progress.
          state_d = S_IDLE;
          done_d  = 1'b0;
          err_d   = 1'b0;
        end else if (accept) begin
          case (state_q)
            S_LEN: begin
              // A zero length byte encodes a full 256-word image.
              len_d   = (rx_data == 8'd0) ? 9'd256 : {1'b0, rx_data};
              state_d = S_HI;
            end
            S_HI: begin
              hi_d    = rx_data;
              acc_d   = acc_q ^ rx_data;
              state_d = S_LO;
            end
            S_LO: begin
              mem_we  = 1'b1;
              acc_d   = acc_q ^ rx_data;
              ptr_d   = ptr_q + 8'd1;
              wc_d    = wc_q + 9'd1;
              state_d = ((wc_q + 9'd1) == len_q) ? S_CSUM : S_HI;
            end
            default: begin
              if (rx_data == acc_q) begin
                state_d = S_DONE;
                done_d  = 1'b1;
                start_d = 1'b1;
              end else begin
                state_d = S_ERR;
                err_d   = 1'b1;
              end
            end
          endcase
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control and datapath registers, cleared asynchronously.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      load_en_q <= 1'b0;
      ptr_q     <= BASE_ADDR;
      acc_q     <= 8'd0;
      hi_q      <= 8'd0;
      len_q     <= 9'd0;
      wc_q      <= 9'd0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      start_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      load_en_q <= load_en_d;
      ptr_q     <= ptr_d;
      acc_q     <= acc_d;
      hi_q      <= hi_d;
      len_q     <= len_d;
      wc_q      <= wc_d;
      done_q    <= done_d;
      err_q     <= err_d;
      start_q   <= start_d;
    end
  end

  // Word write when the low byte of a pair lands.
  always_ff @(posedge clock) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  assign i_datain   = mem[i_addr];
  assign cpu_start  = start_q;
  assign load_done  = done_q;
  assign load_err   = err_q;
  assign word_count = wc_q;

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Instruction memory for the pipelined CPU, 256 x 16. It feeds the CPU's i_addr/i_datain fetch port.
- A byte-serial valid/ready load port fills the memory from a host (UART receiver or bench) before execution.
- While a load is in progress, the block holds the CPU (cpu_hold drives the CPU enable low).
- After a load whose checksum verifies, it pulses cpu_start.

Parameters:
- BASE_ADDR, 8'h00, first memory address written by each load; the address wraps 8'hFF -> 8'h00.

Ports:
- clock  in  1  system clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low.
- load_en  in  1  load request; a rising edge starts a load, and dropping it low mid-load aborts the load.
- rx_valid  in  1  host byte valid.
- rx_data  in  8  host byte.
- rx_ready  out  1  block accepts a byte this cycle.
- i_addr  in  8  CPU fetch address.
- i_datain  out  16  combinational mem[i_addr].
- cpu_hold  out  1  high while loading; CPU enable = enable & ~cpu_hold.
- cpu_start  out  1  one-cycle pulse on successful load.
- load_done  out  1  sticky; last load succeeded.
- load_err  out  1  sticky; last load failed its checksum.
- word_count  out  9  words written by the current or last load.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE.
  - rx_ready, cpu_hold, cpu_start, load_done and load_err are 0.
  - word_count=0, write pointer=BASE_ADDR, checksum accumulator=0, load_en edge register=0.
  - Memory contents are NOT reset.
- Reset mid-load: the same reset values apply immediately. Words already written stay in memory.
- Byte transfer: a byte is accepted on a posedge when rx_valid & rx_ready. rx_data is ignored at all other times.
- Read path: i_datain = mem[i_addr], purely combinational, valid in every state. A word written at a posedge is visible on i_datain after that edge.
- Load frame, in order:
  - Byte 1, length byte L: word count N = L, with L=0 meaning N=256.
  - Next 2N bytes: data, each word sent high byte then low byte.
  - Last byte: checksum, the XOR of all 2N data bytes (the length byte is excluded).
- States:
  - IDLE: rx_ready=0, cpu_hold=0. On a load_en rising edge (load_en=1, previous sample 0), go to LEN.
  - LEN: clear load_done, load_err, word_count and the accumulator; pointer=BASE_ADDR. On accept, latch N and go to HI.
  - HI: on accept, latch the high byte, acc ^= byte, go to LO.
  - LO: on accept:
    - mem[ptr] <= {hi, byte}; acc ^= byte; ptr++ (mod 256); word_count++.
    - If word_count+1 == N, go to CSUM; otherwise go to HI.
  - CSUM: on accept:
    - byte == acc: go to DONE, load_done=1, cpu_start=1 for exactly one cycle (the first DONE cycle).
    - byte != acc: go to ERR, load_err=1, no cpu_start.
  - DONE / ERR: rx_ready=0, cpu_hold=0. Stay until the next load_en rising edge, which goes to LEN. A load_en fall has no effect here.
- rx_ready=1 and cpu_hold=1 exactly in LEN, HI, LO and CSUM.
- Abort: load_en=0 in LEN/HI/LO/CSUM sends the state to IDLE on the next edge.
  - load_done=0, load_err=0.
  - word_count keeps its value; partial words stay written.
  - A byte offered in the same cycle as the abort is not accepted (rx_ready is gated by load_en combinationally).
- rx_valid low gaps of any length are allowed between bytes; back-to-back bytes at one per cycle are supported.
- No timeout.

Test Plan:
- Reset, then idle with load_en=0 -> rx_ready=0, cpu_hold=0, load_done=0, load_err=0, word_count=0.
- BASE_ADDR=0, load_en rise, bytes 03 12 34 AB CD 00 FF BF back-to-back ->
  - mem[0]=1234, mem[1]=ABCD, mem[2]=00FF;
  - word_count=3, load_done=1, a single cpu_start pulse;
  - cpu_hold high from LEN through CSUM;
  - i_addr=1 gives i_datain=ABCD.
- Same frame with checksum byte 0xBE -> load_err=1, load_done=0, no cpu_start; the three words are still written.
- BASE_ADDR=8'hFE, bytes 03 11 11 22 22 33 33 00 with random rx_valid gaps -> mem[FE]=1111, mem[FF]=2222, mem[00]=3333, load_done=1.
- Length 00, 256 words where word k = {k,~k}, checksum 00 -> word_count=256, all locations correct, load_done=1.
- load_en dropped after 1.5 words (bytes 02 AA BB CC) -> mem[0]=AABB, state IDLE, rx_ready=0, cpu_hold=0, word_count=1, no cpu_start.
- Reset asserted mid-HI -> outputs at reset values immediately; the next load_en rise starts a fresh load at BASE_ADDR.
